// File: rtl/power_domain_sequencer.sv
// Power-domain sequencer: walks one switchable domain through
// switch-on, isolation release, clock enable and reset release. Power-down
// runs the same steps in reverse. The power-switch acknowledge is watched
// with a timeout, and a timeout latches a sticky fault flag.
module power_domain_sequencer #(
    parameter int CNT_W       = 8,
    parameter int ISO_DLY     = 4,
    parameter int RST_DLY     = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic pwr_req,
    input  logic sw_ack,
    output logic sw_en,
    output logic iso_en,
    output logic clk_en,
    output logic dom_rstn,
    output logic pwr_on,
    output logic busy,
    output logic err
);

    localparam logic [3:0] S_OFF      = 4'd0;
    localparam logic [3:0] S_SW_ON    = 4'd1;
    localparam logic [3:0] S_ISO_HOLD = 4'd2;
    localparam logic [3:0] S_CLK_ON   = 4'd3;
    localparam logic [3:0] S_ON       = 4'd4;
    localparam logic [3:0] S_RST_ON   = 4'd5;
    localparam logic [3:0] S_ISO_ON   = 4'd6;
    localparam logic [3:0] S_SW_OFF   = 4'd7;
    localparam logic [3:0] S_FAULT    = 4'd8;

    // Terminal counts: a timed state of N cycles leaves when the count is N-1.
    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ack_m;
    logic             ack_s;
    logic [5:0]       out_nxt;

    // Two-flop synchroniser for the asynchronous switch acknowledge
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= sw_ack;
            ack_s <= ack_m;
        end
    end

    // Next-state selection; sequences in either direction always run to completion
    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:      if (pwr_req) state_nxt = S_SW_ON;
            S_SW_ON: begin
                if (ack_s)                state_nxt = S_ISO_HOLD;
                else if (cnt == ACK_LAST) state_nxt = S_FAULT;
            end
            S_ISO_HOLD: if (cnt == ISO_LAST) state_nxt = S_CLK_ON;
            S_CLK_ON:   if (cnt == RST_LAST) state_nxt = S_ON;
            S_ON:       if (!pwr_req) state_nxt = S_RST_ON;
            S_RST_ON:   if (cnt == RST_LAST) state_nxt = S_ISO_ON;
            S_ISO_ON:   if (cnt == ISO_LAST) state_nxt = S_SW_OFF;
            S_SW_OFF: begin
                if (!ack_s)               state_nxt = S_OFF;
                else if (cnt == ACK_LAST) state_nxt = S_FAULT;
            end
            S_FAULT:    if (!pwr_req) state_nxt = S_OFF;
            default:    state_nxt = S_OFF;
        endcase
    end

    // Output decode of the state being entered: {sw_en, iso_en, clk_en, dom_rstn, pwr_on, busy}
    always_comb begin
        out_nxt = 6'b010000;
        case (state_nxt)
            S_OFF:      out_nxt = 6'b010000;
            S_SW_ON:    out_nxt = 6'b110001;
            S_ISO_HOLD: out_nxt = 6'b110001;
            S_CLK_ON:   out_nxt = 6'b101001;
            S_ON:       out_nxt = 6'b101110;
            S_RST_ON:   out_nxt = 6'b101001;
            S_ISO_ON:   out_nxt = 6'b110001;
            S_SW_OFF:   out_nxt = 6'b010001;
            S_FAULT:    out_nxt = 6'b010000;
            default:    out_nxt = 6'b010000;
        endcase
    end

    // State, wait counter and registered Moore outputs, all updated on state entry
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_OFF;
            cnt      <= '0;
            sw_en    <= 1'b0;
            iso_en   <= 1'b1;
            clk_en   <= 1'b0;
            dom_rstn <= 1'b0;
            pwr_on   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            {sw_en, iso_en, clk_en, dom_rstn, pwr_on, busy} <= out_nxt;
            if (state_nxt == S_SW_ON && state != S_SW_ON) begin
                err <= 1'b0;
            end else if (state_nxt == S_FAULT && state != S_FAULT) begin
                err <= 1'b1;
            end
        end
    end

endmodule
